// File: rtl/clk_measure_pkg.sv
// Shared types and helpers for the clock-measurement sequencer.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package clk_measure_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_RUN     = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_CAPTURE = 3'd4
   } t_meas_state;

   // Counters need at least two cycles of reset to clear through their syncs,
   // and capture needs at least one quiet cycle after enable drops.
   localparam int unsigned MIN_RESET_CYCLES  = 2;
   localparam int unsigned MIN_SETTLE_CYCLES = 1;

   // Status word as presented on the CSR read mux.
   function automatic logic [3:0] pack_status(input logic err_window,
                                              input logic timed_out,
                                              input logic done,
                                              input logic busy);
      return {err_window, timed_out, done, busy};
   endfunction

endpackage

// File: rtl/clk_measure_seq.sv
// Sequences one measurement: clear counters, run to window/timeout, settle, snapshot counts.
// Latency: RESET_CYCLES + run + SETTLE_CYCLES + 1 cycles from accepted start to done; all outputs registered.
// Backpressure: none; start while busy is dropped, abort cancels any active measurement next cycle.
module clk_measure_seq
   import clk_measure_pkg::*;
#(
   parameter int unsigned N_COUNTERS    = 6,
   parameter int unsigned COUNTER_WIDTH = 40,
   parameter int unsigned RESET_CYCLES  = 8,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned TIMEOUT_WIDTH = 48,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = {1'b1, {(TIMEOUT_WIDTH-1){1'b0}}}
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic                                abort,
   input  logic [COUNTER_WIDTH-1:0]            window,
   output logic                                busy,
   output logic                                done,
   output logic                                timed_out,
   output logic                                err_window,
   output logic                                cnt_reset_n,
   output logic                                cnt_enable,
   output logic [COUNTER_WIDTH-1:0]            cnt_max,
   input  logic                                max_reached,
   input  logic [N_COUNTERS*COUNTER_WIDTH-1:0] count_in,
   output logic [N_COUNTERS*COUNTER_WIDTH-1:0] result
);

   localparam int unsigned RES_W = N_COUNTERS * COUNTER_WIDTH;

   // The shared timer counts cycles already spent in the current state, so a
   // phase of length L ends when the timer shows L-1.
   localparam logic [TIMEOUT_WIDTH-1:0] CLEAR_LAST   = TIMEOUT_WIDTH'(RESET_CYCLES - 1);
   localparam logic [TIMEOUT_WIDTH-1:0] SETTLE_LAST  = TIMEOUT_WIDTH'(SETTLE_CYCLES - 1);
   localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);

   if (RESET_CYCLES < MIN_RESET_CYCLES) begin : g_bad_reset_cycles
      $error("RESET_CYCLES below minimum");
   end
   if (SETTLE_CYCLES < MIN_SETTLE_CYCLES) begin : g_bad_settle_cycles
      $error("SETTLE_CYCLES below minimum");
   end

   t_meas_state              state_q, state_nxt;
   logic [TIMEOUT_WIDTH-1:0] timer_q, timer_nxt;
   logic                     done_nxt, timed_out_nxt, err_window_nxt;
   logic [COUNTER_WIDTH-1:0] cnt_max_nxt;
   logic [RES_W-1:0]         result_nxt;

   // State and phase timer registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_nxt;
         timer_q <= timer_nxt;
      end
   end

   // Next-state, sticky-flag and snapshot decisions for the current cycle.
   always_comb begin
      state_nxt      = state_q;
      done_nxt       = done;
      timed_out_nxt  = timed_out;
      err_window_nxt = err_window;
      cnt_max_nxt    = cnt_max;
      result_nxt     = result;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               done_nxt      = 1'b0;
               timed_out_nxt = 1'b0;
               if (window == '0) begin
                  err_window_nxt = 1'b1;
               end else begin
                  err_window_nxt = 1'b0;
                  cnt_max_nxt    = window;
                  state_nxt      = ST_CLEAR;
               end
            end
         end
         ST_CLEAR: begin
            if (timer_q == CLEAR_LAST) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // A reference hit in the same cycle as the watchdog is a normal finish.
            if (max_reached) begin
               state_nxt = ST_SETTLE;
            end else if (timer_q == TIMEOUT_LAST) begin
               state_nxt     = ST_SETTLE;
               timed_out_nxt = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (timer_q == SETTLE_LAST) state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            result_nxt = count_in;
            done_nxt   = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Abort discards whatever this cycle would have recorded.
      if (abort && (state_q != ST_IDLE)) begin
         state_nxt     = ST_IDLE;
         done_nxt      = done;
         timed_out_nxt = timed_out;
         result_nxt    = result;
      end

      if ((state_nxt != state_q) || (state_q == ST_IDLE)) begin
         timer_nxt = '0;
      end else begin
         timer_nxt = timer_q + TIMEOUT_WIDTH'(1);
      end
   end

   // Registered outputs, decoded from the state being entered so they align with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         timed_out   <= 1'b0;
         err_window  <= 1'b0;
         cnt_reset_n <= 1'b0;
         cnt_enable  <= 1'b0;
         cnt_max     <= '0;
         result      <= '0;
      end else begin
         busy        <= (state_nxt != ST_IDLE);
         done        <= done_nxt;
         timed_out   <= timed_out_nxt;
         err_window  <= err_window_nxt;
         cnt_reset_n <= (state_nxt != ST_CLEAR);
         cnt_enable  <= (state_nxt == ST_RUN);
         cnt_max     <= cnt_max_nxt;
         result      <= result_nxt;
      end
   end

endmodule

// File: doc/clk_measure_seq.md
# clk_measure_seq

Sequencer that runs one clock-frequency measurement over the bank of `clock_counter` instances in the clock-tutorial AFU. It replaces software-driven toggling of counter reset, enable and max-value CSRs. A single start command clears the counters, runs them until the reference counter hits the programmed window or a timeout expires, lets the cross-domain counts settle, then snapshots all counts into result registers. It sits between the MMIO CSR decode and the counter bank, in the MMIO clock domain.

## Interface
- `N_COUNTERS`, 6: number of counters snapshotted.
- `COUNTER_WIDTH`, 40: width of each count and of the window.
- `RESET_CYCLES`, 8: cycles counter reset is held. Must exceed the counters' reset/sync latency; minimum 2.
- `SETTLE_CYCLES`, 4: cycles between enable drop and capture. Minimum 1.
- `TIMEOUT_WIDTH`, 48: width of the RUN-phase watchdog.
- `TIMEOUT_CYCLES`, 2**47: RUN cycles before forced stop.

Ports:
- `clk` in 1: MMIO-domain clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command pulse.
- `abort` in 1: one-cycle cancel pulse.
- `window` in COUNTER_WIDTH: reference-count target, sampled on accepted start.
- `busy` out 1: measurement in progress.
- `done` out 1: sticky; last measurement completed (normally or by timeout).
- `timed_out` out 1: sticky; last measurement stopped by watchdog.
- `err_window` out 1: sticky; last start rejected because window==0.
- `cnt_reset_n` out 1: to counter `sync_reset_n` terms.
- `cnt_enable` out 1: to counter `enable`.
- `cnt_max` out COUNTER_WIDTH: to reference counter `max_value`.
- `max_reached` in 1: from reference counter.
- `count_in` in N_COUNTERS*COUNTER_WIDTH: live counts; counter i at slice i.
- `result` out N_COUNTERS*COUNTER_WIDTH: snapshot registers.

## Operation
- States:
  - IDLE
  - CLEAR: cnt_reset_n=0, cnt_enable=0.
  - RUN: cnt_reset_n=1, cnt_enable=1.
  - SETTLE: cnt_enable=0.
  - CAPTURE
- IDLE + start, window≠0:
  - latch window into cnt_max
  - clear done/timed_out/err_window
  - go to CLEAR
- IDLE + start, window==0:
  - stay IDLE
  - set err_window; clear done/timed_out
  - result unchanged
- CLEAR → RUN after exactly RESET_CYCLES cycles.
- RUN → SETTLE on max_reached=1, or when the watchdog reaches TIMEOUT_CYCLES (also sets timed_out). If both happen in the same cycle, timed_out stays 0.
- SETTLE → CAPTURE after exactly SETTLE_CYCLES cycles.
- CAPTURE: load result from count_in; set done; → IDLE.
- start while busy: ignored, no flag change.
- abort in any non-IDLE state: → IDLE next cycle, cnt_enable=0, cnt_reset_n=1; done not set; result unchanged.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: start wins.
- A single internal cycle counter serves as the CLEAR, SETTLE and RUN watchdog timer; it is reloaded on every state entry.
- Reset (asynchronous, any time, including mid-run) values:
  - state IDLE
  - busy=0, done=0, timed_out=0, err_window=0
  - cnt_reset_n=0, cnt_enable=0
  - cnt_max=0, result=0
- cnt_reset_n goes to 1 on the first clock edge after reset deasserts.

## Timing
- All outputs are registered.
- start accepted at edge t:
  - busy=1 and cnt_reset_n=0 from t+1
  - cnt_reset_n=1 and cnt_enable=1 from t+1+RESET_CYCLES
- max_reached=1 sampled at edge u: cnt_enable=0 from u+1.
- CAPTURE is at edge u+1+SETTLE_CYCLES; result, done and busy=0 are visible after that edge.
- Back-to-back: a new start is accepted on the first IDLE cycle after completion.
- cnt_max is stable for the whole measurement.

## Structure
- `clk_measure_pkg` holds:
  - state enum `t_meas_state`
  - localparam minimums for RESET_CYCLES and SETTLE_CYCLES
  - a status-word packing function `{err_window, timed_out, done, busy}` for the CSR read mux
- Single module. The counter bank stays external. No sub-module.

## Test plan
- Reset mid-RUN → all outputs at reset values next cycle; stays IDLE with no start.
- start, window=1000, model max_reached at RUN cycle 1000, count_in[0]=1000, count_in[1]=500 → done=1, result slices 1000/500, busy high for exactly RESET_CYCLES+1000+SETTLE_CYCLES+1 cycles.
- start with window=0 → err_window=1, busy stays 0, result unchanged. Following start with window=5 → err_window cleared.
- TIMEOUT_CYCLES=64, max_reached never asserted → timed_out=1, done=1 at RUN cycle 64, result captured.
- abort two cycles into SETTLE → IDLE, done=0, result equals prior snapshot. start pulsed during RUN → ignored.
- max_reached and timeout in the same cycle → timed_out=0, done=1. start and abort in the same IDLE cycle → measurement starts.
